// File: rtl/vending_machine_param.sv
// Parametrised vending machine: multi-coin credit, per-item price table,
// per-item stock counters, vend / refund / change with registered pulses.
// Ports: clk, reset (async, active-high); coin_valid/coin_amt, sel_valid/
// item_code, cancel, restock in; dispense/dispensed_item, change_valid/
// change_amt, credit, coin_reject, sold_out, insufficient out.
module vending_machine_param #(
    parameter int AMT_W      = 8,
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5,
    parameter int MAX_CREDIT = 200,
    parameter logic [NUM_ITEMS*AMT_W-1:0] PRICE_LIST =
        {8'd15, 8'd12, 8'd10, 8'd5}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coin_valid,
    input  logic [AMT_W-1:0]  coin_amt,
    input  logic              sel_valid,
    input  logic [ITEM_W-1:0] item_code,
    input  logic              cancel,
    input  logic              restock,
    output logic              dispense,
    output logic [ITEM_W-1:0] dispensed_item,
    output logic              change_valid,
    output logic [AMT_W-1:0]  change_amt,
    output logic [AMT_W-1:0]  credit,
    output logic              coin_reject,
    output logic              sold_out,
    output logic              insufficient
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;

    localparam logic [NUM_ITEMS-1:0][AMT_W-1:0] PRICES = PRICE_LIST;
    localparam logic [AMT_W:0]   MAX_C  = (AMT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);

    state_e state_q, state_d;
    logic [AMT_W-1:0] credit_q, credit_d;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;

    logic              dispense_q, dispense_d;
    logic [ITEM_W-1:0] item_q, item_d;
    logic              change_valid_q, change_valid_d;
    logic [AMT_W-1:0]  change_amt_q, change_amt_d;
    logic              reject_q, reject_d;
    logic              sold_out_q, sold_out_d;
    logic              insuff_q, insuff_d;

    logic [AMT_W:0]     sum_w;
    logic               coin_over;
    logic [AMT_W-1:0]   sel_price;
    logic [STOCK_W-1:0] sel_stock;

    // One extra bit so an oversized coin cannot wrap under the ceiling.
    assign sum_w     = {1'b0, credit_q} + {1'b0, coin_amt};
    assign coin_over = sum_w > MAX_C;
    assign sel_price = PRICES[item_code];
    assign sel_stock = stock_q[item_code];

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        dispense_d     = 1'b0;
        item_d         = '0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        reject_d       = 1'b0;
        sold_out_d     = 1'b0;
        insuff_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (restock) begin
                    stock_d = {NUM_ITEMS{INIT_S}};
                end
                if (cancel) begin
                    reject_d = coin_valid;
                end else if (sel_valid) begin
                    reject_d = coin_valid;
                    if (sel_stock == '0) begin
                        sold_out_d = 1'b1;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_over) begin
                        reject_d = 1'b1;
                    end else if (coin_amt != '0) begin
                        credit_d = coin_amt;
                        state_d  = CREDIT;
                    end
                end
            end
            CREDIT: begin
                if (cancel) begin
                    reject_d       = coin_valid;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    state_d        = CHANGE;
                end else if (sel_valid) begin
                    reject_d = coin_valid;
                    if (sel_stock == '0) begin
                        sold_out_d = 1'b1;
                    end else if (credit_q < sel_price) begin
                        insuff_d = 1'b1;
                    end else begin
                        credit_d           = credit_q - sel_price;
                        stock_d[item_code] = sel_stock - 1'b1;
                        dispense_d         = 1'b1;
                        item_d             = item_code;
                        state_d            = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_over) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum_w[AMT_W-1:0];
                    end
                end
            end
            VEND: begin
                reject_d = coin_valid;
                // Change pulse is launched here so it lands one cycle
                // after the dispense pulse.
                if (credit_q != '0) begin
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    state_d        = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                reject_d = coin_valid;
                credit_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            stock_q        <= {NUM_ITEMS{INIT_S}};
            dispense_q     <= 1'b0;
            item_q         <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            reject_q       <= 1'b0;
            sold_out_q     <= 1'b0;
            insuff_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            dispense_q     <= dispense_d;
            item_q         <= item_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            reject_q       <= reject_d;
            sold_out_q     <= sold_out_d;
            insuff_q       <= insuff_d;
        end
    end

    assign dispense       = dispense_q;
    assign dispensed_item = item_q;
    assign change_valid   = change_valid_q;
    assign change_amt     = change_amt_q;
    assign credit         = credit_q;
    assign coin_reject    = reject_q;
    assign sold_out       = sold_out_q;
    assign insufficient   = insuff_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed vector table, async reset
// sequences and random stimulus against a transaction-level model.
module tb_vending_machine_param;

    typedef struct packed {
        logic       coin;
        logic [7:0] amt;
        logic       sel;
        logic [1:0] item;
        logic       cancel;
        logic       restock;
    } in_t;

    typedef struct packed {
        logic       disp;
        logic [1:0] ditem;
        logic       cv;
        logic [7:0] camt;
        logic [7:0] credit;
        logic       rej;
        logic       so;
        logic       ins;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_amt = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] item_code = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       dispense;
    logic [1:0] dispensed_item;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sold_out;
    logic       insufficient;

    int vectors = 0;
    int miscompares = 0;

    vending_machine_param dut (
        .clk            (clk),
        .reset          (reset),
        .coin_valid     (coin_valid),
        .coin_amt       (coin_amt),
        .sel_valid      (sel_valid),
        .item_code      (item_code),
        .cancel         (cancel),
        .restock        (restock),
        .dispense       (dispense),
        .dispensed_item (dispensed_item),
        .change_valid   (change_valid),
        .change_amt     (change_amt),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .sold_out       (sold_out),
        .insufficient   (insufficient)
    );

    always #5 clk = ~clk;

    // Reference model: credit 0 means idle, otherwise credit is held.
    // Busy cycles after a vend or refund are queued output records.
    int   price [4] = '{5, 10, 12, 15};
    int   m_credit;
    int   m_stock [4];
    out_t m_q [$];

    task automatic model_reset();
        m_credit = 0;
        for (int k = 0; k < 4; k++) m_stock[k] = 5;
        m_q.delete();
    endtask

    task automatic model(input in_t i, output out_t o);
        bit idle;
        bit launched;
        int rem;
        o = '0;
        launched = 0;
        if (m_q.size() != 0) begin
            o = m_q.pop_front();
            o.rej = i.coin;
            return;
        end
        idle = (m_credit == 0);
        if (i.cancel) begin
            o.rej = i.coin;
            if (!idle) begin
                o.cv = 1'b1;
                o.camt = m_credit[7:0];
                o.credit = m_credit[7:0];
                m_q.push_back('0);
                m_credit = 0;
                launched = 1;
            end
        end else if (i.sel) begin
            o.rej = i.coin;
            if (m_stock[i.item] == 0) begin
                o.so = 1'b1;
            end else if (m_credit < price[i.item]) begin
                o.ins = 1'b1;
            end else begin
                m_stock[i.item]--;
                rem = m_credit - price[i.item];
                o.disp = 1'b1;
                o.ditem = i.item;
                o.credit = rem[7:0];
                if (rem > 0) begin
                    out_t c;
                    c = '0;
                    c.cv = 1'b1;
                    c.camt = rem[7:0];
                    c.credit = rem[7:0];
                    m_q.push_back(c);
                end
                m_q.push_back('0);
                m_credit = 0;
                launched = 1;
            end
        end else if (i.coin) begin
            if (m_credit + int'(i.amt) > 200) o.rej = 1'b1;
            else m_credit += int'(i.amt);
        end
        if (idle && i.restock) begin
            for (int k = 0; k < 4; k++) m_stock[k] = 5;
        end
        if (!launched) o.credit = m_credit[7:0];
    endtask

    function automatic string fmt(input out_t o);
        return $sformatf("disp=%0b item=%0d cv=%0b camt=%0d credit=%0d rej=%0b so=%0b ins=%0b",
                         o.disp, o.ditem, o.cv, o.camt, o.credit,
                         o.rej, o.so, o.ins);
    endfunction

    task automatic check(input string nm, input out_t e);
        out_t a;
        a = {dispense, dispensed_item, change_valid, change_amt,
             credit, coin_reject, sold_out, insufficient};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %s, want %s", nm, fmt(a), fmt(e));
        end
    endtask

    task automatic apply(input in_t i);
        @(negedge clk);
        coin_valid = i.coin;
        coin_amt   = i.amt;
        sel_valid  = i.sel;
        item_code  = i.item;
        cancel     = i.cancel;
        restock    = i.restock;
        @(posedge clk);
        #1;
    endtask

    task automatic mstep(input in_t i, input string nm);
        out_t e;
        model(i, e);
        apply(i);
        check(nm, e);
    endtask

    function automatic in_t ci(bit c, int a, bit s, int it, bit cn, bit rs);
        in_t r;
        r.coin = c;
        r.amt = 8'(a);
        r.sel = s;
        r.item = 2'(it);
        r.cancel = cn;
        r.restock = rs;
        return r;
    endfunction

    function automatic out_t eo(bit d, int it, bit cv, int ca, int cr,
                                bit rj, bit so, bit ins);
        out_t r;
        r.disp = d;
        r.ditem = 2'(it);
        r.cv = cv;
        r.camt = 8'(ca);
        r.credit = 8'(cr);
        r.rej = rj;
        r.so = so;
        r.ins = ins;
        return r;
    endfunction

    function automatic vec_t v(in_t i, out_t e);
        vec_t r;
        r.i = i;
        r.e = e;
        return r;
    endfunction

    vec_t tbl [$];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        apply(ci(0, 0, 0, 0, 0, 0));
        check("reset_state", '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        in_t N, CAN;
        in_t r;
        int  pick;
        N   = ci(0, 0, 0, 0, 0, 0);
        CAN = ci(0, 0, 0, 0, 1, 0);

        // Coins 5+3, buy item0, change 3.
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 5, 0, 0, 0)));
        tbl.push_back(v(ci(1, 3, 0, 0, 0, 0), eo(0, 0, 0, 0, 8, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 1, 0, 0, 0), eo(1, 0, 0, 0, 3, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 1, 3, 3, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        // Insufficient, top up, buy item1, change 2.
        tbl.push_back(v(ci(1, 7, 0, 0, 0, 0), eo(0, 0, 0, 0, 7, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 1, 1, 0, 0), eo(0, 0, 0, 0, 7, 0, 0, 1)));
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 12, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 1, 1, 0, 0), eo(1, 1, 0, 0, 2, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 1, 2, 2, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        // Exact-price item2 five times, no change pulse.
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(v(ci(1, 12, 0, 0, 0, 0), eo(0, 0, 0, 0, 12, 0, 0, 0)));
            tbl.push_back(v(ci(0, 0, 1, 2, 0, 0), eo(1, 2, 0, 0, 0, 0, 0, 0)));
            tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        end
        tbl.push_back(v(ci(1, 12, 0, 0, 0, 0), eo(0, 0, 0, 0, 12, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 1, 2, 0, 0), eo(0, 0, 0, 0, 12, 0, 1, 0)));
        tbl.push_back(v(CAN, eo(0, 0, 1, 12, 12, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 0, 0, 0, 1), eo(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(ci(1, 12, 0, 0, 0, 0), eo(0, 0, 0, 0, 12, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 1, 2, 0, 0), eo(1, 2, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        // Credit ceiling.
        tbl.push_back(v(ci(1, 100, 0, 0, 0, 0), eo(0, 0, 0, 0, 100, 0, 0, 0)));
        tbl.push_back(v(ci(1, 95, 0, 0, 0, 0), eo(0, 0, 0, 0, 195, 0, 0, 0)));
        tbl.push_back(v(ci(1, 10, 0, 0, 0, 0), eo(0, 0, 0, 0, 195, 1, 0, 0)));
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 200, 0, 0, 0)));
        tbl.push_back(v(ci(1, 1, 0, 0, 0, 0), eo(0, 0, 0, 0, 200, 1, 0, 0)));
        tbl.push_back(v(CAN, eo(0, 0, 1, 200, 200, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(ci(1, 201, 0, 0, 0, 0), eo(0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(ci(1, 200, 0, 0, 0, 0), eo(0, 0, 0, 0, 200, 0, 0, 0)));
        tbl.push_back(v(ci(1, 255, 0, 0, 0, 0), eo(0, 0, 0, 0, 200, 1, 0, 0)));
        tbl.push_back(v(CAN, eo(0, 0, 1, 200, 200, 0, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        // Idle oddities.
        tbl.push_back(v(ci(1, 0, 0, 0, 0, 0), eo(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(CAN, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(ci(0, 0, 1, 0, 0, 0), eo(0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(v(ci(1, 5, 1, 0, 1, 0), eo(0, 0, 0, 0, 0, 1, 0, 0)));
        // Priority: cancel beats select and coin.
        tbl.push_back(v(ci(1, 15, 0, 0, 0, 0), eo(0, 0, 0, 0, 15, 0, 0, 0)));
        tbl.push_back(v(ci(1, 5, 1, 3, 1, 0), eo(0, 0, 1, 15, 15, 1, 0, 0)));
        tbl.push_back(v(N, eo(0, 0, 0, 0, 0, 0, 0, 0)));
        // Coin with select, coin during VEND and CHANGE.
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 5, 0, 0, 0)));
        tbl.push_back(v(ci(1, 5, 1, 0, 0, 0), eo(1, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 5, 0, 0, 0)));
        tbl.push_back(v(CAN, eo(0, 0, 1, 5, 5, 0, 0, 0)));
        tbl.push_back(v(ci(1, 5, 0, 0, 0, 0), eo(0, 0, 0, 0, 0, 1, 0, 0)));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[k]) begin
            apply(tbl[k].i);
            check($sformatf("vec%0d", k), tbl[k].e);
        end

        // Async reset in the middle of VEND.
        do_reset();
        mstep(ci(1, 20, 0, 0, 0, 0), "mv_coin");
        mstep(ci(0, 0, 1, 0, 0, 0), "mv_sel");
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_vend", '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mstep(N, "after_reset");
        for (int k = 0; k < 6; k++) begin
            mstep(ci(1, 5, 0, 0, 0, 0), "stock_coin");
            mstep(ci(0, 0, 1, 0, 0, 0), "stock_sel");
            mstep(N, "stock_gap");
        end
        mstep(CAN, "stock_refund");
        mstep(N, "stock_idle");

        // Async reset in the middle of CHANGE.
        do_reset();
        mstep(ci(1, 30, 0, 0, 0, 0), "mc_coin");
        mstep(CAN, "mc_cancel");
        #3;
        reset = 1'b1;
        #1;
        check("reset_mid_change", '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = '0;
            r.coin = ($urandom_range(99) < 45);
            pick = $urandom_range(7);
            case (pick)
                0: r.amt = 8'd0;
                1: r.amt = 8'd1;
                2: r.amt = 8'd5;
                3: r.amt = 8'd10;
                4: r.amt = 8'd25;
                5: r.amt = 8'd50;
                6: r.amt = 8'd100;
                default: r.amt = 8'($urandom_range(255));
            endcase
            r.sel = ($urandom_range(99) < 20);
            r.item = 2'($urandom_range(3));
            r.cancel = ($urandom_range(99) < 5);
            r.restock = ($urandom_range(99) < 3);
            mstep(r, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the team's single-cycle vending machine. Accumulates credit over multiple coin insertions and holds a per-item price table and per-item stock counters. Handles selection, cancel/refund and change return with registered, one-cycle-pulse handshakes. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
AMT_W, 8, width of coin, credit, price and change values
NUM_ITEMS, 4, number of selectable items (power of two)
ITEM_W, 2, item code width, equals log2(NUM_ITEMS)
STOCK_W, 4, width of each stock counter
INIT_STOCK, 5, stock loaded into every item at reset and on restock
MAX_CREDIT, 200, credit ceiling; a coin that would exceed it is rejected
PRICE_LIST, {8'd15,8'd12,8'd10,8'd5}, packed NUM_ITEMS*AMT_W vector; item i price is slice i (item0=5, item1=10, item2=12, item3=15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin_valid  in  1  coin_amt valid this cycle
coin_amt  in  AMT_W  value of inserted coin
sel_valid  in  1  item selection request
item_code  in  ITEM_W  selected item
cancel  in  1  refund request
restock  in  1  reload all stock counters to INIT_STOCK
dispense  out  1  one-cycle pulse, item released
dispensed_item  out  ITEM_W  item being dispensed, valid with dispense
change_valid  out  1  one-cycle pulse, change_amt valid
change_amt  out  AMT_W  change/refund value
credit  out  AMT_W  current accumulated credit
coin_reject  out  1  one-cycle pulse, coin refused
sold_out  out  1  one-cycle pulse, selected item has zero stock
insufficient  out  1  one-cycle pulse, credit < price of selected item

Behaviour:
- Reset (async, any state): state=IDLE; credit=0; all stock=INIT_STOCK; every output 0.
- All outputs are registered. Pulses last exactly one cycle.
- States are IDLE, CREDIT, VEND and CHANGE.
- Same-cycle input priority in IDLE/CREDIT: cancel > sel_valid > coin_valid. A coin arriving with a higher-priority event is rejected (coin_reject=1).
- IDLE:
  - coin_valid with coin_amt>0 and coin_amt<=MAX_CREDIT -> credit=coin_amt, go to CREDIT.
  - coin_amt=0 is ignored with no pulse.
  - coin_amt>MAX_CREDIT -> coin_reject.
  - sel_valid in IDLE -> insufficient pulse (or sold_out if that item's stock is 0).
  - cancel in IDLE is ignored.
  - restock is honoured only in IDLE.
- CREDIT:
  - coin: if credit+coin_amt<=MAX_CREDIT (sum computed at AMT_W+1 bits, no wrap), credit+=coin_amt; else coin_reject and credit unchanged.
  - sel_valid: if stock[item]==0, pulse sold_out and stay.
  - sel_valid: else if credit<price, pulse insufficient and stay.
  - sel_valid: else latch item, credit-=price, decrement stock[item], go to VEND.
  - cancel -> go to CHANGE with the whole credit.
- VEND (1 cycle):
  - dispense=1, dispensed_item=latched item.
  - Next state is CHANGE if credit>0, else IDLE.
- CHANGE (1 cycle):
  - change_valid=1, change_amt=credit.
  - credit=0 on exit, next state IDLE.
- In VEND/CHANGE: every coin_valid is rejected; sel_valid, cancel and restock are ignored.
- Latency:
  - Selection sampled at edge N gives dispense high during cycle N+1.
  - change_valid is high during cycle N+2.
  - Cancel sampled at edge N gives change_valid during cycle N+1.
- Stock counters saturate at 0; they are never decremented below zero because a zero-stock selection is refused.
- Reset mid-VEND/CHANGE: pulses drop immediately, credit is lost, stock returns to INIT_STOCK.

Test Plan:
- Reset, then coins 5 and 3 -> credit=8. Select item0 -> dispense with dispensed_item=0 next cycle, then change_valid with change_amt=3, credit=0, state IDLE.
- Credit 7, select item1 (price 10) -> insufficient pulse, credit stays 7. Add 5 (credit 12), select item1 -> dispense, change_amt=2.
- Credit 12, select item2 -> dispense, no change_valid, IDLE directly. Repeat 5 times -> 6th selection gives sold_out; restock in IDLE restores it.
- Credit 195, coin 10 -> coin_reject, credit stays 195. Cancel -> change_valid with change_amt=195.
- Same cycle, credit 15: cancel+sel_valid(item3)+coin 5 -> refund of 15, no dispense, coin_reject. Coin during VEND -> coin_reject.
- Assert reset during VEND -> dispense drops asynchronously, credit=0, all stock=5.
